// File: rtl/seq_alu.sv
// Sequential multi-cycle ALU: IDLE/EXEC/DONE controller with iterative multiply,
// restoring divide and bit-serial shifts; results are registered at the end of DONE.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_start,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [5:0]       alu_control,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic             alu_done,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] OP_ADD = 5'b01011;
    localparam logic [4:0] OP_SUB = 5'b01100;
    localparam logic [4:0] OP_LSR = 5'b01101;
    localparam logic [4:0] OP_LSL = 5'b01110;
    localparam logic [4:0] OP_ROR = 5'b01111;
    localparam logic [4:0] OP_ROL = 5'b10000;
    localparam logic [4:0] OP_MOV = 5'b10001;
    localparam logic [4:0] OP_MUL = 5'b10010;
    localparam logic [4:0] OP_DIV = 5'b10011;
    localparam logic [4:0] OP_MOD = 5'b10100;
    localparam logic [4:0] OP_AND = 5'b10101;
    localparam logic [4:0] OP_OR  = 5'b10110;
    localparam logic [4:0] OP_XOR = 5'b10111;
    localparam logic [4:0] OP_NOT = 5'b11000;
    localparam logic [4:0] OP_CMP = 5'b11001;
    localparam logic [4:0] OP_TST = 5'b11010;
    localparam logic [4:0] OP_INC = 5'b11011;
    localparam logic [4:0] OP_DEC = 5'b11100;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [4:0]       op_p0;
    logic             unsup_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] hi_p0;
    logic [WIDTH-1:0] lo_p0;
    logic             cf_p0;

    logic             unsup_in;
    logic [CNT_W-1:0] cnt_in;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] res;
    logic             res_cf;
    logic             res_vf;
    logic             res_err;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic [WIDTH-1:0] d);
        return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
    endfunction

    assign busy = (state == ST_EXEC) || (state == ST_DONE);

    // Iteration count chosen at acceptance; zero means a single-step operation.
    always_comb begin
        unsup_in = 1'b0;
        cnt_in   = '0;
        if (alu_control == 6'b111011 || alu_control == 6'b111100) begin
            unsup_in = 1'b1;
        end else if (alu_control[4:0] < OP_ADD || alu_control[4:0] > OP_DEC) begin
            unsup_in = 1'b1;
        end
        if (!unsup_in) begin
            case (alu_control[4:0])
                OP_MUL:         cnt_in = W_CNT;
                OP_DIV, OP_MOD: cnt_in = (op2 == '0) ? '0 : W_CNT;
                OP_LSL, OP_LSR: cnt_in = (op2 >= W_VAL) ? W_CNT : CNT_W'(op2);
                OP_ROL, OP_ROR: cnt_in = CNT_W'(op2 % W_VAL);
                default:        cnt_in = '0;
            endcase
        end
    end

    always_comb begin
        mul_sum   = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, b_p0} : '0);
        div_shift = {hi_p0, lo_p0[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_p0};
    end

    always_comb begin
        b_eff    = (op_p0 == OP_INC || op_p0 == OP_DEC) ? WIDTH'(1) : b_p0;
        add_full = {1'b0, a_p0} + {1'b0, b_eff};
        sub_full = {1'b0, a_p0} - {1'b0, b_eff};
        res      = '0;
        res_cf   = 1'b0;
        res_vf   = 1'b0;
        res_err  = 1'b0;
        if (unsup_p0) begin
            res_err = 1'b1;
        end else begin
            case (op_p0)
                OP_ADD, OP_INC: begin
                    res    = add_full[WIDTH-1:0];
                    res_cf = add_full[WIDTH];
                    res_vf = add_ovf(a_p0, b_eff, add_full[WIDTH-1:0]);
                end
                OP_SUB, OP_CMP, OP_DEC: begin
                    res    = sub_full[WIDTH-1:0];
                    res_cf = a_p0 < b_eff;
                    res_vf = sub_ovf(a_p0, b_eff, sub_full[WIDTH-1:0]);
                end
                OP_MUL: begin
                    res    = lo_p0;
                    res_cf = |hi_p0;
                    res_vf = |hi_p0;
                end
                OP_DIV: begin
                    res     = (b_p0 == '0) ? '1 : lo_p0;
                    res_err = (b_p0 == '0);
                end
                OP_MOD: begin
                    res     = (b_p0 == '0) ? a_p0 : hi_p0;
                    res_err = (b_p0 == '0);
                end
                OP_LSL, OP_LSR, OP_ROL, OP_ROR: begin
                    res    = lo_p0;
                    res_cf = cf_p0;
                end
                OP_AND, OP_TST: res = a_p0 & b_p0;
                OP_OR:          res = a_p0 | b_p0;
                OP_XOR:         res = a_p0 ^ b_p0;
                OP_NOT:         res = ~a_p0;
                OP_MOV:         res = b_p0;
                default:        res_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            out      <= '0;
            flags    <= '0;
            err      <= 1'b0;
            alu_done <= 1'b0;
        end else begin
            alu_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (alu_start) begin
                        state <= ST_EXEC;
                        cnt   <= cnt_in;
                    end
                end
                ST_EXEC: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    out      <= res;
                    flags    <= {(res == '0), res[WIDTH-1], res_cf, res_vf};
                    err      <= res_err;
                    alu_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand capture on acceptance, then one iteration step per EXEC cycle.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && alu_start) begin
            a_p0     <= op1;
            b_p0     <= op2;
            op_p0    <= alu_control[4:0];
            unsup_p0 <= unsup_in;
            hi_p0    <= '0;
            lo_p0    <= op1;
            cf_p0    <= 1'b0;
        end else if (state == ST_EXEC && cnt != '0) begin
            case (op_p0)
                OP_MUL: {hi_p0, lo_p0} <= {mul_sum, lo_p0[WIDTH-1:1]};
                OP_DIV, OP_MOD: begin
                    if (!div_diff[WIDTH]) begin
                        hi_p0 <= div_diff[WIDTH-1:0];
                        lo_p0 <= {lo_p0[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_p0 <= div_shift[WIDTH-1:0];
                        lo_p0 <= {lo_p0[WIDTH-2:0], 1'b0};
                    end
                end
                OP_LSL: begin
                    cf_p0 <= lo_p0[WIDTH-1];
                    lo_p0 <= {lo_p0[WIDTH-2:0], 1'b0};
                end
                OP_LSR: begin
                    cf_p0 <= lo_p0[0];
                    lo_p0 <= {1'b0, lo_p0[WIDTH-1:1]};
                end
                OP_ROL: begin
                    cf_p0 <= lo_p0[WIDTH-1];
                    lo_p0 <= {lo_p0[WIDTH-2:0], lo_p0[WIDTH-1]};
                end
                OP_ROR: begin
                    cf_p0 <= lo_p0[0];
                    lo_p0 <= {lo_p0[0], lo_p0[WIDTH-1:1]};
                end
                default: cf_p0 <= cf_p0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu (WIDTH=16): stimulus pushes expected results,
// an independent monitor pops and checks them on every alu_done pulse.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_start;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [5:0]  alu_control;
    logic [15:0] out;
    logic [3:0]  flags;
    logic        alu_done;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        string       name;
        logic [15:0] o;
        logic [3:0]  f;
        logic        e;
        int          lat;
        int          st;
    } exp_t;

    exp_t sb[$];

    seq_alu #(.WIDTH(16), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .alu_start(alu_start), .op1(op1), .op2(op2),
        .alu_control(alu_control), .out(out), .flags(flags), .alu_done(alu_done),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (alu_done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got out=%0h expected no pulse", out);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk({x.name, "_out"}, 32'(out), 32'(x.o));
                chk({x.name, "_flags"}, 32'(flags), 32'(x.f));
                chk({x.name, "_err"}, 32'(err), 32'(x.e));
                chk({x.name, "_lat"}, 32'(cyc - x.st), 32'(x.lat));
            end
        end
    end

    task automatic issue(input string name, input logic [5:0] c, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eo, input logic [3:0] ef,
                         input logic ee, input int lat);
        exp_t x;
        @(negedge clk);
        alu_control = c;
        op1 = a;
        op2 = b;
        alu_start = 1'b1;
        x.name = name; x.o = eo; x.f = ef; x.e = ee; x.lat = lat; x.st = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        alu_start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic [5:0] c, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eo, input logic [3:0] ef,
                       input logic ee, input int lat);
        issue(name, c, a, b, eo, ef, ee, lat);
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        alu_start = 1'b0;
        op1 = '0;
        op2 = '0;
        alu_control = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(out), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_busy_done_err", 32'({busy, alu_done, err}), 0);

        // reset wins over a simultaneous start
        alu_start = 1'b1;
        alu_control = 6'h0B;
        @(negedge clk);
        alu_start = 1'b0;
        reset = 1'b0;
        chk("rst_prio_busy", 32'(busy), 0);
        @(negedge clk);

        run("add_ovf",  6'h0B, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0, 2);

        // MUL with a second start during EXEC that must be ignored
        issue("mul_big", 6'h12, 16'h0100, 16'h0100, 16'h0000, 4'b1011, 1'b0, 18);
        repeat (4) @(negedge clk);
        alu_start = 1'b1;
        alu_control = 6'h0B;
        chk("mul_busy", 32'(busy), 1);
        chk("hold_out", 32'(out), 32'h8000);
        @(negedge clk);
        alu_start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        run("add_wrap", 6'h2B, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0, 2);
        run("sub_neg",  6'h0C, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0, 2);
        run("sub_ovf",  6'h0C, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b0, 2);
        run("cmp_eq",   6'h19, 16'h0005, 16'h0005, 16'h0000, 4'b1000, 1'b0, 2);
        run("mul_small",6'h12, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1'b0, 18);
        run("div",      6'h13, 16'd100,  16'd7,    16'd14,   4'b0000, 1'b0, 18);
        run("mod",      6'h14, 16'd100,  16'd7,    16'd2,    4'b0000, 1'b0, 18);
        run("div_zero", 6'h13, 16'd5,    16'd0,    16'hFFFF, 4'b0100, 1'b1, 2);
        run("mod_zero", 6'h14, 16'd5,    16'd0,    16'h0005, 4'b0000, 1'b1, 2);
        run("lsl1",     6'h0E, 16'h8001, 16'd1,    16'h0002, 4'b0010, 1'b0, 3);
        run("ror17",    6'h0F, 16'h0001, 16'd17,   16'h8000, 4'b0110, 1'b0, 3);
        run("lsr20",    6'h0D, 16'h8001, 16'd20,   16'h0000, 4'b1010, 1'b0, 18);
        run("rol0",     6'h10, 16'h8001, 16'd0,    16'h8001, 4'b0100, 1'b0, 2);
        run("rol4",     6'h10, 16'h8001, 16'd4,    16'h0018, 4'b0000, 1'b0, 6);
        run("and",      6'h15, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0, 2);
        run("tst",      6'h1A, 16'h0F0F, 16'hF0F0, 16'h0000, 4'b1000, 1'b0, 2);
        run("or",       6'h16, 16'h8000, 16'h0001, 16'h8001, 4'b0100, 1'b0, 2);
        run("xor",      6'h17, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b1000, 1'b0, 2);
        run("not",      6'h18, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1'b0, 2);
        run("mov",      6'h11, 16'hAAAA, 16'h1234, 16'h1234, 4'b0000, 1'b0, 2);
        run("inc",      6'h1B, 16'h7FFF, 16'h0055, 16'h8000, 4'b0101, 1'b0, 2);
        run("dec",      6'h1C, 16'h0000, 16'h0055, 16'hFFFF, 4'b0110, 1'b0, 2);
        run("unsup_3c", 6'h3C, 16'h1234, 16'h0001, 16'h0000, 4'b1000, 1'b1, 2);
        run("unsup_3b", 6'h3B, 16'h1234, 16'h0001, 16'h0000, 4'b1000, 1'b1, 2);
        run("unsup_05", 6'h05, 16'h1234, 16'h0001, 16'h0000, 4'b1000, 1'b1, 2);
        run("err_clear",6'h0B, 16'h4000, 16'h4000, 16'h8000, 4'b0101, 1'b0, 2);

        // reset at cycle 8 of a MUL: no completion, outputs cleared
        @(negedge clk);
        alu_control = 6'h12;
        op1 = 16'h00FF;
        op2 = 16'h00FF;
        alu_start = 1'b1;
        @(negedge clk);
        alu_start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", 32'(out), 0);
        chk("abort_flags", 32'(flags), 0);
        chk("abort_busy_done_err", 32'({busy, alu_done, err}), 0);
        repeat (25) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
